// File: rtl/ram_lsu_ctrl.sv
// ram_lsu_ctrl: load/store controller for a single-port, word-wide RAM with registered read.
// Sub-word stores are done as read-modify-write. Misaligned or illegal-size requests are
// answered with an error and never touch the RAM.
module ram_lsu_ctrl #(
    parameter int unsigned addr_width = 10,
    parameter int unsigned data_width = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [addr_width+1:0]   req_addr,
    input  logic [data_width-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [data_width-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    ram_wr_en,
    output logic [addr_width-1:0]   ram_addr,
    output logic [data_width-1:0]   ram_wdata,
    input  logic [data_width-1:0]   ram_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } state_e;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;
    localparam logic [1:0] SizeIll  = 2'b11;

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [addr_width+1:0]   addr_q, addr_d;
    logic [data_width-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    ram_wr_en_q, ram_wr_en_d;
    logic [addr_width-1:0]   ram_addr_q, ram_addr_d;

    logic                    req_err;
    logic [4:0]              byte_shift;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [data_width-1:0]   load_data;
    logic [data_width-1:0]   merge_data;

    // Alignment / size check on the incoming request.
    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            SizeByte: req_err = 1'b0;
            SizeHalf: req_err = req_addr[0];
            SizeWord: req_err = (req_addr[1:0] != 2'b00);
            SizeIll:  req_err = 1'b1;
            default:  req_err = 1'b1;
        endcase
    end

    // Next state, request capture and next values of the registered control outputs.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (!req_we || (req_size != SizeWord)) begin
                        state_d = StRd;
                    end else begin
                        state_d = StWr;
                    end
                end
            end
            StRd:    state_d = we_q ? StWr : StResp;
            StWr:    state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        req_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StResp);
        ram_wr_en_d = (state_d == StWr);
        ram_addr_d  = (state_d == StIdle) ? '0 : addr_d[addr_width+1:2];
    end

    // State, holding registers and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            ram_wr_en_q <= 1'b0;
            ram_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            ram_wr_en_q <= ram_wr_en_d;
            ram_addr_q  <= ram_addr_d;
        end
    end

    // Lane select and sign/zero extension of the RAM read word for loads.
    always_comb begin
        byte_shift = {addr_q[1:0], 3'b000};
        byte_sel   = ram_rdata[byte_shift +: 8];
        half_sel   = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_data  = ram_rdata;
        unique case (size_q)
            SizeByte: load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SizeHalf: load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            default:  load_data = ram_rdata;
        endcase
    end

    // Store merge: the addressed lane of the old word is replaced by the store data.
    always_comb begin
        merge_data = ram_rdata;
        unique case (size_q)
            SizeByte: merge_data[byte_shift +: 8] = wdata_q[7:0];
            SizeHalf: begin
                if (addr_q[1]) merge_data[31:16] = wdata_q[15:0];
                else           merge_data[15:0]  = wdata_q[15:0];
            end
            default:  merge_data = wdata_q;
        endcase
    end

    // RAM read data stays stable through RESP because the address is held and no write occurs.
    always_comb begin
        req_ready = req_ready_q;
        rsp_valid = rsp_valid_q;
        rsp_err   = rsp_valid_q & err_q;
        rsp_rdata = (rsp_valid_q && !we_q && !err_q) ? load_data : '0;
        ram_wr_en = ram_wr_en_q;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wr_en_q ? merge_data : '0;
    end

endmodule

// File: tb/tb_ram_lsu_ctrl.sv
// Testbench for ram_lsu_ctrl: directed table, randomized ops against a byte-array reference
// model, plus backpressure and reset-during-write sequences.
module tb_ram_lsu_ctrl;

    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem     [0:1023];
    logic [7:0]  ref_mem [0:4095];

    ram_lsu_ctrl #(
        .addr_width(AW),
        .data_width(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .ram_wr_en   (ram_wr_en),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input logic [11:0] a);
        if (sz == 2'd3) return 1'b1;
        return (int'(a) % (1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [1:0] sz,
                                             input logic uns);
        int     n = 1 << sz;
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_ram_wr_en"}, {31'd0, ram_wr_en}, 32'd0);
        chk({tag, "_ram_addr"}, {22'd0, ram_addr}, 32'd0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    endtask

    // One request/response transaction checked against the reference model.
    task automatic do_op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [11:0] a, input logic [31:0] wd, input int bp,
                         output logic [31:0] act_rd, output logic act_err, output int act_lat);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        logic        e_wr;
        int          wr_cnt;
        logic [31:0] wa;
        logic [31:0] wdv;
        int          widx;

        e_err = ref_err(sz, a);
        e_lat = e_err ? 1 : ((we && sz != 2'd2) ? 3 : 2);
        e_rd  = (!we && !e_err) ? ref_load(a, sz, uns) : 32'd0;
        e_wr  = we && !e_err;
        widx  = int'(a) >> 2;
        if (e_wr) begin
            for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        end

        @(negedge clk);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        rsp_ready    = (bp == 0);
        @(posedge clk);
        #1;
        // Scramble request inputs; the in-flight op must not see them.
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = 12'($urandom);
        req_wdata    = $urandom;

        act_lat = 0;
        wr_cnt  = 0;
        wa      = '0;
        wdv     = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ram_wr_en) begin
                wr_cnt++;
                wa  = {22'd0, ram_addr};
                wdv = ram_wdata;
            end
            if (rsp_valid) begin
                act_lat = c;
                break;
            end
        end
        act_rd  = rsp_rdata;
        act_err = rsp_err;
        chk({tag, "_latency"}, act_lat, e_lat);
        chk({tag, "_rdata"}, act_rd, e_rd);
        chk({tag, "_err"}, {31'd0, act_err}, {31'd0, e_err});
        chk({tag, "_wr_count"}, wr_cnt, e_wr ? 1 : 0);
        if (e_wr) begin
            chk({tag, "_wr_addr"}, wa, widx);
            chk({tag, "_wr_data"}, wdv, ref_word(widx));
        end

        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, e_rd);
            chk({tag, "_hold_err"}, {31'd0, rsp_err}, {31'd0, e_err});
            chk({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_rsp_dropped"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_ready_again"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_mem_word"}, mem[widx[9:0]], ref_word(widx));
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [11:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          bp;
    } vec_t;

    vec_t        vt [12];
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] saved;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;

        #3 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

        //        we    sz     uns   addr     wdata          exp_rd         err  lat bp
        vt[0]  = '{1'b1, 2'd2, 1'b0, 12'h008, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0};
        vt[1]  = '{1'b0, 2'd2, 1'b0, 12'h008, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        vt[2]  = '{1'b1, 2'd0, 1'b0, 12'h00A, 32'h00000012, 32'h00000000, 1'b0, 3, 0};
        vt[3]  = '{1'b1, 2'd1, 1'b0, 12'h008, 32'h00005678, 32'h00000000, 1'b0, 3, 0};
        vt[4]  = '{1'b0, 2'd2, 1'b0, 12'h008, 32'h0,        32'hDE125678, 1'b0, 2, 5};
        vt[5]  = '{1'b0, 2'd0, 1'b0, 12'h00B, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 0};
        vt[6]  = '{1'b0, 2'd0, 1'b1, 12'h00B, 32'h0,        32'h000000DE, 1'b0, 2, 0};
        vt[7]  = '{1'b0, 2'd1, 1'b0, 12'h008, 32'h0,        32'h00005678, 1'b0, 2, 0};
        vt[8]  = '{1'b0, 2'd1, 1'b0, 12'h00A, 32'h0,        32'hFFFFDE12, 1'b0, 2, 0};
        vt[9]  = '{1'b0, 2'd2, 1'b0, 12'h006, 32'h0,        32'h00000000, 1'b1, 1, 0};
        vt[10] = '{1'b0, 2'd3, 1'b0, 12'h008, 32'h0,        32'h00000000, 1'b1, 1, 0};
        vt[11] = '{1'b1, 2'd1, 1'b0, 12'h009, 32'h0000AAAA, 32'h00000000, 1'b1, 1, 3};

        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vt[i].we, vt[i].sz, vt[i].uns, vt[i].a, vt[i].wd,
                  vt[i].bp, rd, er, lat);
            chk($sformatf("vec%0d_tab_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_tab_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
            chk($sformatf("vec%0d_tab_lat", i), lat, vt[i].exp_lat);
        end

        // Reset asserted mid-cycle during WR of a byte store: no write may land.
        saved = mem[2];
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd0;
        req_addr  = 12'h009;
        req_wdata = 32'h000000AB;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstwr_in_wr", {31'd0, ram_wr_en}, 32'd1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("rstwr");
        @(negedge clk);
        rst = 1'b0;
        chk("rstwr_mem_unchanged", mem[2], saved);
        do_op("rstwr_reload", 1'b0, 2'd2, 1'b0, 12'h008, 32'h0, 0, rd, er, lat);
        chk("rstwr_reload_value", rd, 32'hDE125678);

        // Randomized operations over a small address window to force overlap.
        for (int i = 0; i < 150; i++) begin
            do_op($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom), 12'($urandom_range(0, 63)), $urandom,
                  int'($urandom_range(0, 2)), rd, er, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_lsu_ctrl.md
# ram_lsu_ctrl

Load/store controller that drives the single-port, word-wide, registered-read data RAM on behalf of the core's memory stage. Accepts byte/halfword/word load and store requests with byte addresses over a valid/ready handshake. Converts them into RAM word accesses, performing read-modify-write for sub-word stores. Returns sign- or zero-extended load data or store completion over a valid/ready response channel, and rejects misaligned or illegal-size requests without touching the RAM.

## Interface
- addr_width, 10: RAM word-address width; byte address is addr_width+2 bits
- data_width, 32: data width; only 32 is supported
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  addr_width+2  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned address or illegal size
- ram_wr_en  out  1  RAM write strobe
- ram_addr  out  addr_width  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM registered read data, valid the cycle after ram_addr is presented with ram_wr_en=0

## Operation
- Request captured into holding registers on the edge where req_valid && req_ready.
- Error check at capture: size 11; half with addr[0]=1; word with addr[1:0]!=00. Error goes IDLE->RESP with rsp_err=1 and no RAM access.
- States: IDLE, RD, WR, RESP.
  - IDLE: on accept, go to RESP on error; else go to RD for a load or byte/half store; else go to WR for a word store.
  - RD: go to WR for a store; else go to RESP.
  - WR: go to RESP.
  - RESP: go to IDLE when rsp_ready.
- ram_addr = held byte address [addr_width+1:2] in every non-IDLE state, and 0 in IDLE.
- ram_wr_en = 1 only in WR. RAM read data is therefore stable through RESP.
- Lanes are little-endian. Byte lane = addr[1:0]; half lane = addr[1].
- Load extract: select lane from ram_rdata, then extend per req_unsigned. Word loads pass through unchanged.
- Store merge in WR: word stores put req_wdata on ram_wdata. Sub-word stores put ram_rdata with the selected lane replaced by req_wdata[7:0] or [15:0].
- ram_wdata = 0 outside WR.
- rsp_rdata, rsp_err are valid only while rsp_valid and are held stable until the handshake completes.

## Timing
- Reset (async): state IDLE, holding registers 0.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_wr_en=0, ram_addr=0, ram_wdata=0.
- Latency, counted from accept cycle 0 to first rsp_valid cycle:
  - load: 2
  - word store: 2
  - byte/half store: 3
  - error: 1
- The RAM write lands on the edge ending the WR cycle.
- rsp_valid held with all response fields constant while rsp_ready=0. The RESP->IDLE edge drops rsp_valid.
- No accept while busy. Minimum spacing between accepts is 3 cycles (load/word store) with rsp_ready tied high.
- Reset asserted during WR before the edge means no RAM write occurs. Reset in any state discards the request and any pending response.
- req_* inputs are ignored outside IDLE. Changes after accept do not affect the in-flight operation.

## Test plan
- Reset then idle:
  - rst pulse mid-cycle asynchronously forces all outputs to reset values.
  - req_ready=1 the following cycle.
- Word store then load:
  - Store 0xDEADBEEF to byte addr 0x008. Expect ram_wr_en=1 with ram_addr=2 in cycle 1, rsp_valid in cycle 2.
  - Load word from 0x008. Expect rsp_rdata=0xDEADBEEF, rsp_err=0 in cycle 2.
- Sub-word RMW:
  - With word 2 = 0xDEADBEEF, store byte 0x12 to 0x00A. Expect RD cycle 1, then WR cycle 2 with ram_wdata=0xDE12BEEF, then rsp cycle 3.
  - Store half 0x5678 to 0x008. Expect word 2 = 0xDE125678.
- Load extension, with word 2 = 0xDE125678:
  - Signed byte at 0x00B gives 0xFFFFFFDE.
  - Unsigned byte at 0x00B gives 0x000000DE.
  - Signed half at 0x008 gives 0x00005678.
  - Signed half at 0x00A gives 0xFFFFDE12.
- Errors:
  - Word load at 0x006 gives rsp_err=1 in cycle 1, rsp_rdata=0, ram_wr_en never high.
  - req_size=11 gives the same response.
- Backpressure and reset mid-op:
  - Hold rsp_ready=0 for 5 cycles. rsp_valid and rsp_rdata stay constant and req_ready stays 0.
  - Assert rst during WR of a byte store. No RAM write, and the target word is unchanged on a later load.
